fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch sequencer for the 8-bit processor: owns the program counter and drives the address of the 256x16 instruction memory.
- Registers the returned instruction into a one-entry output slot and hands it to decode with a valid/ready handshake.
- Supports branch redirect and a HALT opcode.
- Sits between the instruction memory (combinational read) and the decode/execute stage.

Parameters:
ADDR_W, 8, instruction-memory address / PC width
INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 8'h00, PC value after reset and after start from HALT
HALT_OP, 4'hF, opcode that stops fetching

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins fetching from IDLE or HALT
imem_addr  out  ADDR_W  address to instruction memory; equals the internal pc register
imem_instr  in  INSTR_W  instruction from memory, same cycle as imem_addr
instr_out  out  INSTR_W  registered instruction to decode
instr_pc  out  ADDR_W  address that instr_out was fetched from
instr_valid  out  1  instr_out holds an undelivered instruction
instr_ready  in  1  decode accepts instr_out this cycle
redirect_valid  in  1  branch taken; discard the slot and restart fetch
redirect_addr  in  ADDR_W  branch target
busy  out  1  state == RUN
halted  out  1  state == HALT

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, pc = RESET_PC.
  - instr_out = 0, instr_pc = 0, instr_valid = 0, busy = 0, halted = 0.
- Reset mid-operation flushes the slot immediately; no partial delivery.
- Handshake: transfer occurs when instr_valid && instr_ready. slot_free = !instr_valid || instr_ready.
- IDLE:
  - No fetch.
  - start -> RUN. pc is unchanged (RESET_PC).
  - redirect_valid is ignored.
- RUN, in priority order each cycle:
  1. redirect_valid:
     - pc <= redirect_addr; instr_valid <= 0.
     - Any same-cycle transfer still counts as accepted by decode.
     - No fetch this cycle; the first target fetch happens the next cycle.
  2. slot_free and imem_instr opcode == HALT_OP:
     - No load; instr_valid <= 0; pc holds (points at the HALT).
     - state <= HALT.
  3. slot_free, any other opcode:
     - instr_out <= imem_instr; instr_pc <= pc; instr_valid <= 1.
     - pc <= pc + 1, wrapping 8'hFF -> 8'h00.
  4. Otherwise (valid && !ready, a stall): all registers hold; instr_out is stable for the whole stall.
  - start is ignored in RUN.
- HALT:
  - instr_valid = 0; no fetch.
  - start -> pc <= RESET_PC, state <= RUN.
  - redirect_valid is ignored.
- Latency and throughput:
  - start at edge N -> RUN at N+1 -> first instr_valid at N+2.
  - With instr_ready held high: one instruction per cycle.
  - Redirect costs one bubble cycle.
- The HALT instruction itself is never delivered to decode.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[15:0] (counts handshakes) and stall_cnt[15:0] (counts cycles with instr_valid && !instr_ready in RUN).
  - Both counters saturate at 16'hFFFF.
  - Both clear on reset and on an accepted start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package proc_pkg holds:
  - ADDR_W, INSTR_W.
  - Opcode field positions and opcode constants, including OP_HALT = 4'hF.
  - typedef fetch_state_t {IDLE, RUN, HALT}.
- Sub-module fetch_perf_cnt (two saturating counters) is instantiated only under FETCH_PERF_CNT_EN.
- The PC and FSM stay in fetch_ctrl.

Test Plan:
- Straight-line: memory 0..3 = 16'h0123, 16'h1456, 16'h2712, 16'h3821, then 16'hF000 at 4; start with ready=1 -> instr_out sequence 0123, 1456, 2712, 3821 with instr_pc 0..3 on consecutive cycles starting 2 cycles after start; then halted=1, instr_valid=0, imem_addr=4.
- Stall: ready=0 for 3 cycles while instr_out=16'h1456 -> instr_out, instr_pc=1 and pc=2 are stable; on release the next cycle delivers 16'h2712.
- Redirect: redirect_valid with redirect_addr=8'h40 while the slot holds pc 2 -> next cycle instr_valid=0; the following cycle delivers mem[0x40] with instr_pc=8'h40.
- Wrap: redirect to 8'hFF with mem[FF]=16'h0111, mem[00]=16'h0222 -> delivers instr_pc FF then 00.
- Reset mid-stall: drop rst_n while valid && !ready -> instr_valid=0 and state IDLE immediately; start -> fetch resumes at RESET_PC.
- Perf (macro on): 4 accepts with 3 stall cycles -> fetch_cnt=4, stall_cnt=3; a start from HALT clears both to 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared widths, opcode encoding and fetch FSM states for the 8-bit processor.
package proc_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    // The opcode sits in the top nibble of every instruction word.
    localparam int OPC_W   = 4;
    localparam int OPC_MSB = INSTR_W - 1;
    localparam int OPC_LSB = INSTR_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h3;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory port, decode handshake and branch redirect.
interface fetch_ctrl_if;
    import proc_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;

    modport master (
        output imem_addr, instr_out, instr_pc, instr_valid,
        input  imem_instr, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  imem_addr, instr_out, instr_pc, instr_valid,
        output imem_instr, instr_ready, redirect_valid, redirect_addr
    );

endinterface

// File: rtl/fetch_ctrl_perf_cnt.sv
// Saturating 16-bit handshake and stall counters for the fetch stage.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (clear) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fills a one-entry instruction slot, handles redirect and HALT.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_ctrl
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [OPC_W-1:0]  HALT_OP  = OP_HALT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    fetch_ctrl_if.master bus,
    output logic         busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]  fetch_cnt,
    output logic [15:0]  stall_cnt,
`endif
    output logic         halted
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               valid_q;
    logic               slot_free;

    assign slot_free = !valid_q || bus.instr_ready;

    // NOTE: every register here is assigned with <= so all state updates
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        // Target fetch starts next cycle: one bubble.
                        pc      <= bus.redirect_addr;
                        valid_q <= 1'b0;
                    end else if (slot_free) begin
                        if (opcode_of(bus.imem_instr) == HALT_OP) begin
                            // PC is left pointing at the HALT word.
                            valid_q <= 1'b0;
                            state   <= HALT;
                        end else begin
                            instr_q    <= bus.imem_instr;
                            instr_pc_q <= pc;
                            valid_q    <= 1'b1;
                            pc         <= pc + 1'b1;
                        end
                    end
                end
                HALT: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        pc    <= RESET_PC;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign busy            = (state == RUN);
    assign halted          = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic start_accept;
    assign start_accept = start && (state == IDLE || state == HALT);

    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_accept),
        .fetch_inc (valid_q && bus.instr_ready),
        .stall_inc (valid_q && !bus.instr_ready && state == RUN),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: straight-line, stall, redirect, wrap, reset and HALT cases.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [0:255];

    fetch_ctrl_if bus ();

    assign bus.imem_instr = mem[bus.imem_addr];

    fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.master),
        .busy      (busy),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
`endif
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc, busy, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b out=%h pc=%h busy=%b halted=%b, want all 0",
                     bus.instr_valid, bus.instr_out, bus.instr_pc, busy, halted);
        end
        n_cmp++;
        if (bus.imem_addr !== 8'h00) begin
            n_err++;
            $display("FAIL reset_pc: imem_addr=%h want 00", bus.imem_addr);
        end
        // Redirect must be ignored while IDLE.
        bus.redirect_addr  = 8'h55;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if ({busy, bus.imem_addr} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL idle_redirect: busy=%b imem_addr=%h want busy=0 addr=00", busy, bus.imem_addr);
        end
    endtask

    task automatic test_straight_line();
        logic [15:0] exp [4];
        exp[0] = 16'h0123; exp[1] = 16'h1456; exp[2] = 16'h2712; exp[3] = 16'h3821;
        bus.instr_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if ({busy, bus.instr_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL start_latency: busy=%b valid=%b want busy=1 valid=0", busy, bus.instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr_out} !== {1'b1, 8'(i), exp[i]}) begin
                n_err++;
                $display("FAIL straight_%0d: valid=%b pc=%h out=%h want 1 %h %h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr_out, 8'(i), exp[i]);
            end
        end
        step();
        n_cmp++;
        if ({halted, busy, bus.instr_valid, bus.imem_addr} !== {3'b100, 8'h04}) begin
            n_err++;
            $display("FAIL halt_stop: halted=%b busy=%b valid=%b addr=%h want 1 0 0 04",
                     halted, busy, bus.instr_valid, bus.imem_addr);
        end
    endtask

    task automatic test_halt_ignores_redirect();
        bus.redirect_addr  = 8'h55;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if ({halted, bus.instr_valid, bus.imem_addr} !== {2'b10, 8'h04}) begin
            n_err++;
            $display("FAIL halt_redirect: halted=%b valid=%b addr=%h want 1 0 04",
                     halted, bus.instr_valid, bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if ({busy, bus.imem_addr} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL restart_pc: busy=%b addr=%h want 1 00", busy, bus.imem_addr);
        end
        step();
        step();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_addr} !== {1'b1, 16'h1456, 8'h01, 8'h02}) begin
                n_err++;
                $display("FAIL stall_hold_%0d: valid=%b out=%h pc=%h addr=%h want 1 1456 01 02",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_addr);
            end
        end
        bus.instr_ready = 1'b1;
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h2712, 8'h02}) begin
            n_err++;
            $display("FAIL stall_release: valid=%b out=%h pc=%h want 1 2712 02",
                     bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
    endtask

    task automatic test_redirect();
        bus.redirect_addr  = 8'h40;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 8'h40}) begin
            n_err++;
            $display("FAIL redirect_bubble: valid=%b addr=%h want 0 40", bus.instr_valid, bus.imem_addr);
        end
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h0440, 8'h40}) begin
            n_err++;
            $display("FAIL redirect_target: valid=%b out=%h pc=%h want 1 0440 40",
                     bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        mem[8'hFF] = 16'h0111;
        mem[8'h00] = 16'h0222;
        bus.redirect_addr  = 8'hFF;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL wrap_bubble: valid=%b addr=%h want 0 ff", bus.instr_valid, bus.imem_addr);
        end
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h0111, 8'hFF}) begin
            n_err++;
            $display("FAIL wrap_ff: valid=%b out=%h pc=%h want 1 0111 ff",
                     bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_addr} !== {1'b1, 16'h0222, 8'h00, 8'h01}) begin
            n_err++;
            $display("FAIL wrap_00: valid=%b out=%h pc=%h addr=%h want 1 0222 00 01",
                     bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.instr_ready = 1'b0;
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out} !== {1'b1, 16'h0222}) begin
            n_err++;
            $display("FAIL pre_reset_stall: valid=%b out=%h want 1 0222", bus.instr_valid, bus.instr_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.instr_valid, busy, halted, bus.instr_out, bus.imem_addr} !== {3'b000, 16'h0000, 8'h00}) begin
            n_err++;
            $display("FAIL async_reset: valid=%b busy=%b halted=%b out=%h addr=%h want 0 0 0 0000 00",
                     bus.instr_valid, busy, halted, bus.instr_out, bus.imem_addr);
        end
        #2 rst_n = 1'b1;
        step();
        mem[8'h00] = 16'h0123;
        bus.instr_ready = 1'b1;
        pulse_start();
        step();
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h0123, 8'h00}) begin
            n_err++;
            $display("FAIL resume_after_reset: valid=%b out=%h pc=%h want 1 0123 00",
                     bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic wait_halted(input string tag);
        int cyc = 0;
        while (!halted && cyc < 40) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: halted=%b want 1 within 40 cycles", tag, halted);
        end
    endtask

    task automatic test_perf();
        bus.instr_ready = 1'b1;
        wait_halted("perf_pre");
        pulse_start();
        n_cmp++;
        if ({fetch_cnt, stall_cnt} !== 32'h0) begin
            n_err++;
            $display("FAIL perf_clear: fetch_cnt=%0d stall_cnt=%0d want 0 0", fetch_cnt, stall_cnt);
        end
        step();
        step();
        bus.instr_ready = 1'b0;
        step(); step(); step();
        bus.instr_ready = 1'b1;
        wait_halted("perf_run");
        n_cmp++;
        if ({fetch_cnt, stall_cnt} !== {16'd4, 16'd3}) begin
            n_err++;
            $display("FAIL perf_counts: fetch_cnt=%0d stall_cnt=%0d want 4 3", fetch_cnt, stall_cnt);
        end
        pulse_start();
        n_cmp++;
        if ({fetch_cnt, stall_cnt} !== 32'h0) begin
            n_err++;
            $display("FAIL perf_clear_halt: fetch_cnt=%0d stall_cnt=%0d want 0 0", fetch_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'h00, 8'(i)};
        end
        mem[8'h00] = 16'h0123;
        mem[8'h01] = 16'h1456;
        mem[8'h02] = 16'h2712;
        mem[8'h03] = 16'h3821;
        mem[8'h04] = 16'hF000;
        mem[8'h40] = 16'h0440;

        start              = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        rst_n              = 1'b0;
        #23 rst_n = 1'b1;
        step();

        test_reset();
        test_straight_line();
        test_halt_ignores_redirect();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_stall();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
